// File: rtl/instr_encoder_loader_pkg.sv
// MIPS field widths, format codes, common opcode/funct constants and loader states.
// No logic; shared by the loader, its field packer and program sources.
package instr_encoder_loader_pkg;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-set input handshake plus instruction-memory write port.
// master = program source, slave = loader.
interface instr_encoder_loader_if
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         fmt;
    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_wdata;

    modport master (
        output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_packer.sv
// Packs fmt + MIPS fields into a 32-bit instruction word; flags fmt=11 as illegal.
// Purely combinational, zero latency; no backpressure.
module instr_encoder_loader_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]         fmt,
    input  logic [OP_W-1:0]    opcode,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IMM_W-1:0]   imm,
    input  logic [TGT_W-1:0]   target,
    output logic [31:0]        word,
    output logic               legal
);
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   word = {opcode, rs, rt, imm};
            FMT_J:   word = {opcode, target};
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field sets into MIPS words and streams them to instruction memory.
// Latency: transfer in cycle N -> registered write in cycle N+1; one word per cycle.
// Backpressure: in_ready only in LOAD; FULL/IDLE/DONE refuse input (valid while FULL sets err).
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    finish,
    instr_encoder_loader_if.slave   bus,
    output logic [ADDR_W:0]         instr_cnt,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word;
    logic              legal;

    instr_encoder_loader_packer u_packer (
        .fmt    (bus.fmt),
        .opcode (bus.opcode),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .rd     (bus.rd),
        .shamt  (bus.shamt),
        .funct  (bus.funct),
        .imm    (bus.imm),
        .target (bus.target),
        .word   (word),
        .legal  (legal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        // start overrides everything, including a same-cycle finish
        if (start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (legal) begin
                            we_d    = 1'b1;
                            addr_d  = BASE_C + cnt_q[ADDR_W-1:0];
                            wdata_d = word;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (finish)
                        state_d = ST_DONE;
                    else if (cnt_d == DEPTH_C)
                        state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (bus.in_valid)
                        err_d = 1'b1;
                    if (finish)
                        state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign instr_cnt     = cnt_q;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_FULL);
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;
endmodule
